mux_out_serializer: RTL
=======================

# mux_out_serializer

Drain sequencer placed directly behind the 8-channel output multiplexer in the AXI control wrapper. On a start pulse it walks the enabled channels in ascending order and, for each channel, reads a programmed number of words from that channel's result buffer. It drives the mux select and buffer read address, absorbs the one-cycle buffer read latency, and emits the words as an AXI4-Stream master frame with TLAST on the final beat and full backpressure support.

## Interface

- DATA_WIDTH, 16, width of each channel word, the mux output and TDATA.
- ADDR_WIDTH, 10, width of the per-channel buffer address and of the word count.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- num_words  in  ADDR_WIDTH  words per enabled channel; latched on an accepted start.
- ch_mask  in  8  bit i high enables channel i; latched on an accepted start.
- rd_addr  out  ADDR_WIDTH  read address broadcast to all channel buffers (registered).
- mux_sel  out  3  select for the 8:1 mux (registered).
- mux_data  in  DATA_WIDTH  mux output, valid one cycle after the matching rd_addr.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the last beat of the frame.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the frame completes.

## Operation

- States are IDLE, RUN, DRAIN and DONE.
- **IDLE, start = 1:**
  - Latch num_words and ch_mask.
  - If ch_mask = 0 or num_words = 0, go to DONE with no beats.
  - Otherwise set the issue channel to the lowest set mask bit, set the issue address to 0, and go to RUN.
- **Read issue (RUN):**
  - A read is issued in a cycle only when (fifo_count + pending − pop) ≤ 1.
    - pending = a read was issued in the previous cycle.
    - pop = m_axis_tvalid & m_axis_tready in this cycle.
  - An issue increments the address.
  - When address = num_words−1 is issued, the address resets to 0 and the channel advances to the next set mask bit.
  - After the last address of the highest enabled channel is issued, go to DRAIN.
- **Return path:**
  - mux_sel always equals the channel of the read issued in the previous cycle.
  - When pending = 1, mux_data is written into a 2-entry FIFO, together with a last flag.
  - The last flag is set only for the final word of the frame.
  - mux_sel and rd_addr hold their values when no read is issued.
- **Stream:**
  - FIFO head drives tdata and tlast; tvalid = FIFO non-empty.
  - Once tvalid is high, tdata and tlast stay stable until the handshake completes.
  - The FIFO never overflows; overflow is a design error and an assertion target.
- **DRAIN:** when the beat with tlast is accepted, go to DONE.
- **DONE:** done = 1 for one cycle, then go to IDLE.
- start is ignored outside IDLE, including in DONE.
- Total beats per frame = popcount(ch_mask) × num_words. Channel order is ascending; disabled channels are skipped with no idle cycle.
- Reset at any point returns to IDLE, flushes the FIFO and pending read, and drops any frame in progress.

## Timing

- **Reset values:** rd_addr = 0, mux_sel = 0, m_axis_tdata = 0, m_axis_tvalid = 0, m_axis_tlast = 0, busy = 0, done = 0.
- start at cycle T → first rd_addr issued in cycle T+1.
- First matching mux_data is sampled in cycle T+2.
- First m_axis_tvalid is high in cycle T+3.
- With m_axis_tready held high, the block sustains 1 beat per cycle with no bubbles, including across channel boundaries.
- Last beat accepted in cycle L → done = 1 in cycle L+1; busy = 0 and state = IDLE from cycle L+2.
- If m_axis_tready is low for N cycles, issue stalls within 1 cycle. No word is lost or duplicated, and the stream resumes at full rate.
- Empty frame (mask = 0 or num_words = 0): start at T → done = 1 at T+1. busy never rises and no beat is emitted.

## Test plan

- **Full frame, no stall:** ch_mask = 0xFF, num_words = 4, tready = 1, buffer i holding word (i<<8)|addr → 32 beats 0x0000..0x0003, 0x0100..0x0703 in order. tlast only on 0x0703; first tvalid at T+3; done one cycle after the last beat.
- **Sparse mask:** ch_mask = 0x29, num_words = 3 → beats from channels 0, 3 and 5 only (9 beats), with no gap at the channel switches.
- **Backpressure:** ch_mask = 0x03, num_words = 5, tready toggling 1,0,0,1 repeatedly → all 10 beats unique and ordered; tdata stable while stalled; FIFO never exceeds 2 entries.
- **Empty frame:** ch_mask = 0x00, num_words = 7 → done at T+1 with no tvalid; repeat with ch_mask = 0xFF, num_words = 0 → same response.
- **Start while busy, then reset:** pulse start mid-frame → ignored and the frame unchanged. Assert rst_n = 0 for 1 cycle mid-frame → all outputs at reset values next cycle. A new start afterwards runs a clean frame from channel-0 address 0.

Source files
------------

// File: rtl/mux_out_serializer.sv
// Drain sequencer for the 8:1 output mux: walks enabled channels, reads num_words
// words from each result buffer and streams them out as one AXI4-Stream frame.
module mux_out_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic [7:0]            ch_mask,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [2:0]            mux_sel,
    input  logic [DATA_WIDTH-1:0] mux_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    state_t                        state, state_nx;
    logic [ADDR_WIDTH-1:0]         nw_r, addr_r;
    logic [7:0]                    mask_r;
    logic [2:0]                    ch_r, nxt_ch, low_ch;
    logic                          has_nxt, start_empty;
    logic                          pend, pend_last, busy_r;
    logic [1:0][DATA_WIDTH-1:0]    fd;
    logic [1:0]                    fl;
    logic                          wp, rp;
    logic [1:0]                    cnt;
    logic                          pop, issue, addr_end, iss_last;
    logic [8:0]                    below9;
    logic [7:0]                    higher;

    assign m_axis_tvalid = (cnt != 2'd0);
    assign m_axis_tdata  = fd[rp];
    assign m_axis_tlast  = m_axis_tvalid & fl[rp];
    assign busy          = busy_r;
    assign done          = (state == DONE);

    assign pop         = m_axis_tvalid & m_axis_tready;
    assign start_empty = (ch_mask == 8'd0) || (num_words == '0);
    assign addr_end    = (addr_r == nw_r - ONE);

    // Occupancy after this cycle's write/pop must leave room for the read issued now.
    assign issue    = (state == RUN) &&
                      (({1'b0, cnt} + {2'b0, pend}) <= (3'd1 + {2'b0, pop}));
    assign iss_last = issue && addr_end && !has_nxt;

    // Channels strictly above the current one that are still enabled.
    assign below9 = (9'd2 << ch_r) - 9'd1;
    assign higher = mask_r & ~below9[7:0];

    always_comb begin
        nxt_ch  = ch_r;
        has_nxt = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (higher[i]) begin
                nxt_ch  = 3'(i);
                has_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        low_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) low_ch = 3'(i);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = start_empty ? DONE : RUN;
            RUN:     if (iss_last) state_nx = DRAIN;
            DRAIN:   if (pop && m_axis_tlast) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            nw_r      <= '0;
            mask_r    <= '0;
            ch_r      <= '0;
            addr_r    <= '0;
            rd_addr   <= '0;
            mux_sel   <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            busy_r    <= 1'b0;
            fd        <= '0;
            fl        <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            cnt       <= 2'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                nw_r   <= num_words;
                mask_r <= ch_mask;
                ch_r   <= low_ch;
                addr_r <= '0;
                busy_r <= !start_empty;
            end
            if (state == DONE) busy_r <= 1'b0;
            if (issue) begin
                rd_addr <= addr_r;
                mux_sel <= ch_r;
                if (addr_end) begin
                    addr_r <= '0;
                    ch_r   <= nxt_ch;
                end else begin
                    addr_r <= addr_r + ONE;
                end
            end
            pend      <= issue;
            pend_last <= iss_last;
            // Buffer data for last cycle's read is on mux_data now.
            if (pend) begin
                fd[wp] <= mux_data;
                fl[wp] <= pend_last;
                wp     <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, pend} - {1'b0, pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pend && !pop && cnt == 2'd2));

endmodule
